// File: rtl/helios_pkg.sv
// Shared constants, FSM state encoding and grid-size helpers for the Helios host link.
package helios_pkg;

   localparam logic [7:0] START_DECODING_MSG      = 8'h01;
   localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_HDR    = 3'd1,
      ST_LOAD        = 3'd2,
      ST_PRESENT     = 3'd3,
      ST_WAIT_RESULT = 3'd4,
      ST_SEND        = 3'd5
   } state_e;

   // Bytes needed to carry one round of the X*Z syndrome grid.
   function automatic int calc_bpr(input int wx, input int wz);
      return (wx * wz + 7) / 8;
   endfunction

   // Byte-aligned bit pitch of one round inside the measurement image.
   function automatic int calc_apr(input int wx, input int wz);
      return 8 * calc_bpr(wx, wz);
   endfunction

endpackage

// File: rtl/helios_host_interface_result_serializer.sv
// Emits a 24-bit result as three bytes, MSB first, over a valid/ready port.
module result_serializer (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [23:0] load_data,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        done
);

   logic [23:0] data_q, data_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        vld_q, vld_d;

   assign out_data  = data_q[23:16];
   assign out_valid = vld_q;
   // Pulses together with acceptance of the third byte.
   assign done      = vld_q & out_ready & (cnt_q == 2'd2);

   // Load a fresh word or shift one byte out per accepted transfer.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      if (load) begin
         data_d = load_data;
         cnt_d  = 2'd0;
         vld_d  = 1'b1;
      end else if (vld_q && out_ready) begin
         data_d = {data_q[15:0], 8'h00};
         cnt_d  = cnt_q + 2'd1;
         if (cnt_q == 2'd2) vld_d = 1'b0;
      end
   end

   // Serializer state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: rtl/helios_host_interface.sv
// Host-side framing: parses the byte stream into a syndrome image, hands it to
// the decoder core, and returns the core's iteration/cycle counts as three bytes.
module helios_host_interface
   import helios_pkg::*;
#(
   parameter int GRID_WIDTH_X = 8,
   parameter int GRID_WIDTH_Z = 4,
   parameter int GRID_WIDTH_U = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  input_data,
   input  logic        input_valid,
   output logic        input_ready,
   output logic [7:0]  output_data,
   output logic        output_valid,
   input  logic        output_ready,
   output logic [calc_apr(GRID_WIDTH_X, GRID_WIDTH_Z)*GRID_WIDTH_U-1:0] measurements,
   output logic        meas_valid,
   input  logic        meas_ready,
   input  logic [7:0]  result_iterations,
   input  logic [15:0] result_cycles,
   input  logic        result_valid,
   output logic        protocol_error
);

   localparam int BPR   = calc_bpr(GRID_WIDTH_X, GRID_WIDTH_Z);
   localparam int APR   = calc_apr(GRID_WIDTH_X, GRID_WIDTH_Z);
   localparam int NB    = BPR * GRID_WIDTH_U;
   localparam int MW    = APR * GRID_WIDTH_U;
   localparam int CNT_W = $clog2(NB + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [MW-1:0]    meas_q, meas_d;
   logic [23:0]      res_q, res_d;
   logic             perr_q, perr_d;
   logic             rdy_q, rdy_d;
   logic             mvld_q, mvld_d;
   logic             ser_load, ser_done, acc;

   assign acc            = input_valid & rdy_q;
   assign input_ready    = rdy_q;
   assign meas_valid     = mvld_q;
   assign measurements   = meas_q;
   assign protocol_error = perr_q;

   // Frame parser / handshake sequencer. Handshake flags are decoded from the
   // next state and registered, so ready never depends on input_valid.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      meas_d   = meas_q;
      res_d    = res_q;
      perr_d   = perr_q;
      ser_load = 1'b0;
      case (state_q)
         ST_IDLE: if (acc) begin
            if (input_data == START_DECODING_MSG) state_d = ST_WAIT_HDR;
            else                                  perr_d  = 1'b1;
         end
         ST_WAIT_HDR: if (acc) begin
            if (input_data == MEASUREMENT_DATA_HEADER) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               meas_d  = '0;
            end else if (input_data != START_DECODING_MSG) begin
               perr_d = 1'b1;
            end
         end
         ST_LOAD: if (acc) begin
            meas_d[{cnt_q, 3'b000} +: 8] = input_data;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NB - 1)) state_d = ST_PRESENT;
         end
         ST_PRESENT: if (meas_ready) state_d = ST_WAIT_RESULT;
         ST_WAIT_RESULT: if (result_valid) begin
            res_d    = {result_iterations, result_cycles};
            ser_load = 1'b1;
            state_d  = ST_SEND;
         end
         ST_SEND: if (ser_done) state_d = ST_WAIT_HDR;
         default: state_d = ST_IDLE;
      endcase
      rdy_d  = (state_d == ST_IDLE) || (state_d == ST_WAIT_HDR) || (state_d == ST_LOAD);
      mvld_d = (state_d == ST_PRESENT);
   end

   // State and datapath registers; reset drops any partial frame or result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         meas_q  <= '0;
         res_q   <= '0;
         perr_q  <= 1'b0;
         rdy_q   <= 1'b0;
         mvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         meas_q  <= meas_d;
         res_q   <= res_d;
         perr_q  <= perr_d;
         rdy_q   <= rdy_d;
         mvld_q  <= mvld_d;
      end
   end

   result_serializer u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .load_data (res_d),
      .out_data  (output_data),
      .out_valid (output_valid),
      .out_ready (output_ready),
      .done      (ser_done)
   );

endmodule

// File: tb/tb_helios_host_interface.sv
// Directed bench for helios_host_interface at default grid size (28 bytes/frame).
module tb_helios_host_interface;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   input_data;
   logic         input_valid;
   logic         input_ready;
   logic [7:0]   output_data;
   logic         output_valid;
   logic         output_ready;
   logic [223:0] measurements;
   logic         meas_valid;
   logic         meas_ready;
   logic [7:0]   result_iterations;
   logic [15:0]  result_cycles;
   logic         result_valid;
   logic         protocol_error;

   int checks = 0;
   int errors = 0;
   logic [223:0] exp_img;

   always #5 clk = ~clk;

   helios_host_interface dut (
      .clk               (clk),
      .reset             (reset),
      .input_data        (input_data),
      .input_valid       (input_valid),
      .input_ready       (input_ready),
      .output_data       (output_data),
      .output_valid      (output_valid),
      .output_ready      (output_ready),
      .measurements      (measurements),
      .meas_valid        (meas_valid),
      .meas_ready        (meas_ready),
      .result_iterations (result_iterations),
      .result_cycles     (result_cycles),
      .result_valid      (result_valid),
      .protocol_error    (protocol_error)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk); #1;
   endtask

   // Present one byte and wait (bounded) until it is accepted; valid stays high.
   task automatic send_byte(input logic [7:0] b);
      bit ok = 0;
      input_data  = b;
      input_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (input_ready) ok = 1;
         step();
      end
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic send_frame(input logic [7:0] fill, input bit use_index);
      for (int n = 0; n < 28; n++) send_byte(use_index ? 8'(n) : fill);
      input_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0; step(); step();
      reset = 1'b1; step();
   endtask

   initial begin
      reset = 1'b0; input_data = '0; input_valid = 0; output_ready = 0;
      meas_ready = 0; result_iterations = '0; result_cycles = '0; result_valid = 0;
      step(); step();
      // Reset state
      chk("rst_ready",  input_ready,    0);
      chk("rst_ovalid", output_valid,   0);
      chk("rst_odata",  output_data,    0);
      chk("rst_mvalid", meas_valid,     0);
      chk("rst_meas",   measurements,   0);
      chk("rst_perr",   protocol_error, 0);
      reset = 1'b1; step();
      chk("idle_ready", input_ready, 1);

      // Basic frame of A5
      send_byte(8'h01); send_byte(8'h02);
      for (int n = 0; n < 27; n++) send_byte(8'hA5);
      chk("mvalid_before_last", meas_valid, 0);
      send_byte(8'hA5); input_valid = 0;
      chk("mvalid_after_last", meas_valid, 1);
      chk("ready_in_present", input_ready, 0);
      chk("meas_a5", measurements, {28{8'hA5}});

      // Result return, output_ready held high
      meas_ready = 1; step(); meas_ready = 0;
      chk("mvalid_dropped", meas_valid, 0);
      result_iterations = 8'h05; result_cycles = 16'h1234; result_valid = 1;
      output_ready = 1; step(); result_valid = 0;
      chk("b0_valid", output_valid, 1);
      chk("b0_data",  output_data,  8'h05);
      chk("ready_in_send", input_ready, 0);
      step(); chk("b1_data", output_data, 8'h12); chk("b1_valid", output_valid, 1);
      step(); chk("b2_data", output_data, 8'h34); chk("b2_valid", output_valid, 1);
      step(); chk("after_send_valid", output_valid, 0);
      chk("meas_stable_after_send", measurements, {28{8'hA5}});
      output_ready = 0;

      // Back-to-back frame without new start byte
      send_byte(8'h02); send_frame(8'h00, 0);
      chk("b2b_mvalid", meas_valid, 1);
      chk("b2b_meas",   measurements, 0);
      chk("b2b_perr",   protocol_error, 0);

      // Stalled send: output_ready toggles
      meas_ready = 1; step(); meas_ready = 0;
      result_iterations = 8'hAB; result_cycles = 16'hCDEF; result_valid = 1;
      step(); result_valid = 0;
      output_ready = 1;
      chk("t0_data", output_data, 8'hAB);
      step(); output_ready = 0;
      chk("t1_data", output_data, 8'hCD);
      step(); output_ready = 1;
      chk("t2_hold", output_data, 8'hCD); chk("t2_valid", output_valid, 1);
      step(); output_ready = 0;
      chk("t3_data", output_data, 8'hEF);
      step(); output_ready = 1;
      chk("t4_hold", output_data, 8'hEF); chk("t4_valid", output_valid, 1);
      step(); output_ready = 0;
      chk("t5_valid", output_valid, 0);

      // Protocol error in IDLE is sticky; following frame still decodes
      do_reset();
      send_byte(8'h7F); input_valid = 0; step();
      chk("perr_set", protocol_error, 1);
      send_byte(8'h01); send_byte(8'h02); send_frame(8'h00, 1);
      for (int n = 0; n < 28; n++) exp_img[8*n +: 8] = 8'(n);
      chk("perr_frame_meas", measurements, exp_img);
      chk("perr_frame_mvalid", meas_valid, 1);
      chk("perr_sticky", protocol_error, 1);

      // Reset mid-load
      do_reset();
      send_byte(8'h01); send_byte(8'h02);
      for (int n = 0; n < 10; n++) send_byte(8'hFF);
      input_valid = 0;
      reset = 1'b0; #2;
      chk("midrst_meas",   measurements, 0);
      chk("midrst_ready",  input_ready, 0);
      chk("midrst_perr",   protocol_error, 0);
      step(); reset = 1'b1; step();
      // A header byte in IDLE is a protocol error, proving the FSM restarted in IDLE.
      send_byte(8'h02); input_valid = 0; step();
      chk("midrst_idle", protocol_error, 1);
      send_byte(8'h01); send_byte(8'h02);
      for (int n = 0; n < 28; n++) begin
         result_iterations = 8'h99; result_cycles = 16'h9999;
         result_valid = (n == 5);
         send_byte(8'h3C);
         result_valid = 0;
      end
      input_valid = 0;
      chk("reload_meas",   measurements, {28{8'h3C}});
      chk("reload_mvalid", meas_valid, 1);
      chk("stale_res_ov0", output_valid, 0);
      output_ready = 1; meas_ready = 1; step(); meas_ready = 0;
      step(); step();
      chk("stale_res_ov1", output_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/helios_host_interface.md
HELIOS_HOST_INTERFACE -- requirements
Module: helios_host_interface

Interface
REQ-001 SHALL have parameter GRID_WIDTH_X, default 8, meaning X extent of the syndrome grid.
REQ-002 SHALL have parameter GRID_WIDTH_Z, default 4, meaning Z extent of the syndrome grid.
REQ-003 SHALL have parameter GRID_WIDTH_U, default 7, meaning number of measurement rounds.
REQ-004 SHALL derive BPR = ceil(GRID_WIDTH_X*GRID_WIDTH_Z/8) bytes per round, APR = 8*BPR aligned bits per round, and NB = BPR*GRID_WIDTH_U total measurement bytes.
REQ-005 Ports SHALL be exactly, with clk and reset first:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- input_data  in  8  host byte stream
- input_valid  in  1  host byte valid
- input_ready  out  1  byte accepted when valid&ready
- output_data  out  8  result byte stream
- output_valid  out  1  result byte valid
- output_ready  in  1  host accepts result byte
- measurements  out  APR*GRID_WIDTH_U  assembled syndrome image; bit index i*GRID_WIDTH_Z+j+k*APR
- meas_valid  out  1  image complete, held until accepted
- meas_ready  in  1  decoder core accepts image
- result_iterations  in  8  core iteration count
- result_cycles  in  16  core cycle count
- result_valid  in  1  one-cycle result strobe from core
- protocol_error  out  1  sticky; unexpected header byte seen

Function
REQ-006 SHALL implement FSM states IDLE, WAIT_HDR, LOAD, PRESENT, WAIT_RESULT, SEND.
REQ-007 IDLE: input_ready=1; byte START_DECODING_MSG -> WAIT_HDR; any other byte dropped and sets protocol_error.
REQ-008 WAIT_HDR: input_ready=1; byte MEASUREMENT_DATA_HEADER -> LOAD, clear byte counter and the whole measurements register; START_DECODING_MSG is accepted and ignored; any other byte dropped and sets protocol_error.
REQ-009 LOAD: input_ready=1; accepted byte n SHALL be written to measurements[8n +: 8], then the counter increments. On acceptance of byte NB-1, the FSM SHALL go to PRESENT. Cycles with input_valid=0 SHALL stall without state change.
REQ-010 PRESENT: meas_valid=1 and input_ready=0; on meas_ready=1 -> WAIT_RESULT.
REQ-011 WAIT_RESULT: on result_valid=1, latch result_iterations and result_cycles and go to SEND with byte index 0. result_valid SHALL be ignored in every other state.
REQ-012 SEND: output_valid=1; output_data SHALL be iterations, then cycles[15:8], then cycles[7:0], advancing only on output_ready=1. On acceptance of the third byte -> WAIT_HDR. output_valid SHALL deassert in the cycle after the last byte is accepted.
REQ-013 measurements SHALL remain stable from entry into PRESENT until the next MEASUREMENT_DATA_HEADER is accepted.
REQ-014 input_ready SHALL be 0 in PRESENT, WAIT_RESULT and SEND. output_valid SHALL be 0 outside SEND.
REQ-015 All handshake outputs SHALL be registered-state decodes, with no combinational path from input_valid to input_ready.
REQ-016 protocol_error SHALL clear only on reset.

Reset
REQ-017 Asserting reset (low) SHALL immediately force: state IDLE, measurements=0, counters=0, meas_valid=0, output_valid=0, output_data=0, input_ready=0 while reset is low, protocol_error=0, latched results=0.
REQ-018 Reset mid-LOAD or mid-SEND SHALL discard partial data. After release, the host SHALL restart with START_DECODING_MSG.

Structure
REQ-019 START_DECODING_MSG (8'h01) and MEASUREMENT_DATA_HEADER (8'h02), the FSM state enum, and the BPR/APR helper functions SHALL reside in the shared parameters package.
REQ-020 The SEND byte serializer SHALL be a sub-module named result_serializer (24-bit load, 8-bit valid/ready out). Everything else SHALL remain flat.

Verification
REQ-021 Defaults, send 01, 02, then 28 bytes 8'hA5 with input_valid always 1 -> meas_valid rises 1 cycle after the 28th byte; every measurement byte reads A5.
REQ-022 After REQ-021, meas_ready=1, then result_valid with iterations=8'h05, cycles=16'h1234, output_ready=1 -> output bytes 05, 12, 34 on consecutive cycles, then output_valid=0.
REQ-023 Back-to-back: after SEND, send 02 plus 28 bytes 00 without a new 01 -> second image accepted; measurements all zero; protocol_error stays 0.
REQ-024 In IDLE send 7F -> byte consumed, protocol_error=1 and stays 1; a following 01, 02 frame still decodes correctly.
REQ-025 Assert reset low after 10 of 28 LOAD bytes -> measurements=0 and FSM in IDLE; a full new frame decodes correctly; result_valid pulsed while in LOAD produces no output bytes.
REQ-026 Toggle output_ready 1,0,1,0 during SEND -> bytes delivered in order with no duplication or loss, and output_data held stable while stalled.
